data_sync_mc: RTL and testbench
===============================

// Module: data_sync_mc
// PURPOSE
//  Multi-channel, destination-side bus synchroniser for the UART system. Each channel
//  brings a data bus and its qualifier from a foreign clock domain into CLK. It detects
//  a new-data event in level or toggle mode, captures the bus, and holds it under a
//  valid/ready handshake with overrun detection. A toggle ack output lets the source
//  domain pace transfers. Successor to the single-channel pulse-mode synchroniser.
// PARAMETERS
//  NUM_STAGES   2  flops per qualifier synchroniser chain (>=2)
//  BUS_WIDTH    8  data bits per channel
//  NUM_CH       1  number of independent channels (>=1)
//  ENABLE_MODE  0  0 = level: event on rising edge of Bus_Enable; 1 = toggle: event on any change
//  OVERWRITE    1  1 = event during pending data overwrites it; 0 = new data dropped
// PORTS
//  CLK           in   1                 destination clock
//  RST           in   1                 async active-low reset
//  UNSYNC_BUS    in   NUM_CH*BUS_WIDTH  source data, channel i at [i*BUS_WIDTH +: BUS_WIDTH]
//  Bus_Enable    in   NUM_CH            per-channel qualifier from source domain
//  Data_Ready    in   NUM_CH            consumer accepts SYNC_BUS slice
//  Overrun_Clr   in   NUM_CH            clears sticky Overrun bit
//  SYNC_BUS      out  NUM_CH*BUS_WIDTH  captured data, registered
//  Enable_Pulse  out  NUM_CH            1-cycle strobe when a slice is (re)loaded
//  Data_Valid    out  NUM_CH            slice holds unconsumed data
//  Overrun       out  NUM_CH            sticky: event arrived while Data_Valid & ~Data_Ready
//  Sync_Ack      out  NUM_CH            toggles once per accepted transfer (for source domain)
// BEHAVIOUR
//  Reset: all outputs, sync chains and edge-history flops = 0; asynchronous on RST low.
//  Chain: Bus_Enable[i] -> NUM_STAGES flops -> sync_q; prev_q <= sync_q every cycle.
//  Event: mode0 ev = sync_q & ~prev_q; mode1 ev = sync_q ^ prev_q (combinational).
//  Latency: Bus_Enable change sampled at edge 1 -> ev during cycle after edge NUM_STAGES
//   -> SYNC_BUS/Enable_Pulse/Data_Valid updated at edge NUM_STAGES+1.
//  UNSYNC_BUS slice must be stable from the Bus_Enable change through edge NUM_STAGES+1;
//   the source guarantees this. The bus is never synchronised bitwise.
//  Load (edge with ev): if ~Data_Valid | Data_Ready | OVERWRITE -> SYNC_BUS<=UNSYNC_BUS,
//   Enable_Pulse<=1, Data_Valid<=1. Otherwise the slice is held, Enable_Pulse<=0.
//  Overrun: set on ev & Data_Valid & ~Data_Ready; cleared by Overrun_Clr. Set wins if same cycle.
//  Accept: Data_Valid & Data_Ready at edge -> Data_Valid<=0 unless loading the same edge
//   (stays 1 with new data); Sync_Ack toggles on every accept.
//  Enable_Pulse is 1 for exactly one cycle per load; 0 otherwise.
//  SYNC_BUS holds its value when not loading, including after accept.
//  Channels fully independent; simultaneous events on several channels all served same cycle.
//  Reset mid-transfer: state lost, no pulse. In mode0, Bus_Enable held high across reset
//   release produces one event NUM_STAGES+1 cycles later. In mode1, source toggle must
//   reset to 0 to avoid a spurious event.
// STRUCTURE
//  Sub-module data_sync_chan: one channel (chain, edge detect, capture, handshake, ack).
//   Top = generate loop over NUM_CH plus bus slicing.
//  Shared package: ENABLE_MODE encodings (SYNC_MODE_LEVEL=0, SYNC_MODE_TOGGLE=1), default
//   NUM_STAGES. No typedefs required.
// TESTING
//  1 Reset: RST=0 mid-run -> all outputs 0 immediately; hold Bus_Enable=1 through release
//    (mode0) -> Enable_Pulse after exactly NUM_STAGES+1 edges.
//  2 Latency mode0, NUM_STAGES=2: UNSYNC_BUS=8'hA5, Bus_Enable 0->1 at edge 1
//    -> SYNC_BUS=8'hA5, Enable_Pulse=1, Data_Valid=1 after edge 3; pulse 0 after edge 4.
//  3 Toggle mode: Bus_Enable toggles 0->1 then 1->0 (data 8'h11, 8'h22, 8 cycles apart)
//    -> two pulses, SYNC_BUS 8'h11 then 8'h22.
//  4 Handshake: Data_Ready=0 then second event 8'h3C -> Overrun=1. OVERWRITE=1: SYNC_BUS=8'h3C;
//    OVERWRITE=0: old data kept, no pulse. Overrun_Clr -> Overrun=0.
//  5 Accept + same-edge load: Data_Ready=1 on edge of new load -> Data_Valid stays 1,
//    Sync_Ack toggles once.
//  6 NUM_CH=3, NUM_STAGES=3: simultaneous events on ch0/ch2 -> both pulse same cycle,
//    ch1 SYNC_BUS unchanged.

Source files
------------

// File: rtl/data_sync_mc_pkg.sv
// Shared constants for the multi-channel destination-side bus synchroniser.
//   SYNC_MODE_LEVEL   : new-data event on a rising edge of the synchronised qualifier
//   SYNC_MODE_TOGGLE  : new-data event on any change of the synchronised qualifier
//   DEFAULT_NUM_STAGES: default depth of each qualifier synchroniser chain
package data_sync_mc_pkg;

    localparam int SYNC_MODE_LEVEL    = 0;
    localparam int SYNC_MODE_TOGGLE   = 1;
    localparam int DEFAULT_NUM_STAGES = 2;

endpackage

// File: rtl/data_sync_chan.sv
// One synchroniser channel: qualifier sync chain, edge detect, bus capture,
// valid/ready hold with sticky overrun, and a toggle ack for the source domain.
// Ports:
//   i_clk, i_rst_n      destination clock, async active-low reset
//   i_bus               source data slice (held stable by the source around an event)
//   i_enable            qualifier from the source domain
//   i_ready             consumer accepts o_bus
//   i_overrun_clr       clears the sticky overrun flag
//   o_bus               captured data, held until the next load
//   o_pulse             one-cycle strobe on each load
//   o_valid             o_bus holds unconsumed data
//   o_overrun           event arrived while data was pending and not being accepted
//   o_ack               toggles once per accepted transfer
module data_sync_chan
    import data_sync_mc_pkg::*;
#(
    parameter int NUM_STAGES  = DEFAULT_NUM_STAGES,
    parameter int BUS_WIDTH   = 8,
    parameter int ENABLE_MODE = SYNC_MODE_LEVEL,
    parameter int OVERWRITE   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [BUS_WIDTH-1:0] i_bus,
    input  logic                 i_enable,
    input  logic                 i_ready,
    input  logic                 i_overrun_clr,
    output logic [BUS_WIDTH-1:0] o_bus,
    output logic                 o_pulse,
    output logic                 o_valid,
    output logic                 o_overrun,
    output logic                 o_ack
);

    logic [NUM_STAGES-1:0] r_sync;
    logic                  r_prev;
    logic [BUS_WIDTH-1:0]  r_bus;
    logic                  r_pulse;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  r_ack;

    logic w_sync_q;
    logic w_event;
    logic w_load;
    logic w_accept;

    assign w_sync_q = r_sync[NUM_STAGES-1];

    generate
        if (ENABLE_MODE == SYNC_MODE_TOGGLE) begin : g_toggle
            assign w_event = w_sync_q ^ r_prev;
        end else begin : g_level
            assign w_event = w_sync_q & ~r_prev;
        end
    endgenerate

    // With OVERWRITE set, an event always reloads even if the old data is unconsumed.
    assign w_load   = w_event & (~r_valid | i_ready | (OVERWRITE != 0));
    assign w_accept = r_valid & i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync    <= '0;
            r_prev    <= 1'b0;
            r_bus     <= '0;
            r_pulse   <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_sync  <= {r_sync[NUM_STAGES-2:0], i_enable};
            r_prev  <= w_sync_q;
            r_pulse <= w_load;

            if (w_load) begin
                r_bus <= i_bus;
            end

            // A load on the accept edge keeps the slice valid with the new data.
            if (w_load) begin
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            // Setting has priority over a same-cycle clear.
            if (w_event & r_valid & ~i_ready) begin
                r_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                r_overrun <= 1'b0;
            end

            if (w_accept) begin
                r_ack <= ~r_ack;
            end
        end
    end

    assign o_bus     = r_bus;
    assign o_pulse   = r_pulse;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
    assign o_ack     = r_ack;

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel destination-side bus synchroniser: NUM_CH independent
// data_sync_chan instances, each owning one BUS_WIDTH slice of the buses.
// Ports:
//   CLK, RST        destination clock, async active-low reset
//   UNSYNC_BUS      source data, channel i at [i*BUS_WIDTH +: BUS_WIDTH]
//   Bus_Enable      per-channel qualifier from the source domain
//   Data_Ready      per-channel consumer accept
//   Overrun_Clr     per-channel sticky overrun clear
//   SYNC_BUS        captured data, same slicing as UNSYNC_BUS
//   Enable_Pulse    per-channel one-cycle load strobe
//   Data_Valid      per-channel unconsumed-data flag
//   Overrun         per-channel sticky overrun flag
//   Sync_Ack        per-channel toggle per accepted transfer
module data_sync_mc
    import data_sync_mc_pkg::*;
#(
    parameter int NUM_STAGES  = DEFAULT_NUM_STAGES,
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_CH      = 1,
    parameter int ENABLE_MODE = SYNC_MODE_LEVEL,
    parameter int OVERWRITE   = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic [NUM_CH-1:0]           Bus_Enable,
    input  logic [NUM_CH-1:0]           Data_Ready,
    input  logic [NUM_CH-1:0]           Overrun_Clr,
    output logic [NUM_CH*BUS_WIDTH-1:0] SYNC_BUS,
    output logic [NUM_CH-1:0]           Enable_Pulse,
    output logic [NUM_CH-1:0]           Data_Valid,
    output logic [NUM_CH-1:0]           Overrun,
    output logic [NUM_CH-1:0]           Sync_Ack
);

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            data_sync_chan #(
                .NUM_STAGES  (NUM_STAGES),
                .BUS_WIDTH   (BUS_WIDTH),
                .ENABLE_MODE (ENABLE_MODE),
                .OVERWRITE   (OVERWRITE)
            ) u_chan (
                .i_clk         (CLK),
                .i_rst_n       (RST),
                .i_bus         (UNSYNC_BUS[g*BUS_WIDTH +: BUS_WIDTH]),
                .i_enable      (Bus_Enable[g]),
                .i_ready       (Data_Ready[g]),
                .i_overrun_clr (Overrun_Clr[g]),
                .o_bus         (SYNC_BUS[g*BUS_WIDTH +: BUS_WIDTH]),
                .o_pulse       (Enable_Pulse[g]),
                .o_valid       (Data_Valid[g]),
                .o_overrun     (Overrun[g]),
                .o_ack         (Sync_Ack[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_data_sync_mc.sv
// Bench for data_sync_mc: three 3-channel instances
//   inst 0: NUM_STAGES=2, level mode,  OVERWRITE=1
//   inst 1: NUM_STAGES=2, toggle mode, OVERWRITE=0
//   inst 2: NUM_STAGES=3, level mode,  OVERWRITE=1
// A reference model works from the sampled history of Bus_Enable: the event seen
// at edge k compares the samples taken at edges k-NS and k-NS-1.
module tb_data_sync_mc;

    logic        CLK;
    logic        RST;
    logic [23:0] ub  [3];
    logic [2:0]  be  [3];
    logic [2:0]  rdy [3];
    logic [2:0]  clr [3];
    logic [23:0] sb  [3];
    logic [2:0]  ep  [3];
    logic [2:0]  dv  [3];
    logic [2:0]  ov  [3];
    logic [2:0]  ack [3];

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] m_bus   [3][3];
    logic       m_valid [3][3];
    logic       m_pulse [3][3];
    logic       m_ovr   [3][3];
    logic       m_ack   [3][3];
    logic [7:0] m_hist  [3][3];
    int         hold    [3][3];

    data_sync_mc #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(3), .ENABLE_MODE(0), .OVERWRITE(1)) u_dut0 (
        .CLK(CLK), .RST(RST), .UNSYNC_BUS(ub[0]), .Bus_Enable(be[0]), .Data_Ready(rdy[0]),
        .Overrun_Clr(clr[0]), .SYNC_BUS(sb[0]), .Enable_Pulse(ep[0]), .Data_Valid(dv[0]),
        .Overrun(ov[0]), .Sync_Ack(ack[0]));

    data_sync_mc #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(3), .ENABLE_MODE(1), .OVERWRITE(0)) u_dut1 (
        .CLK(CLK), .RST(RST), .UNSYNC_BUS(ub[1]), .Bus_Enable(be[1]), .Data_Ready(rdy[1]),
        .Overrun_Clr(clr[1]), .SYNC_BUS(sb[1]), .Enable_Pulse(ep[1]), .Data_Valid(dv[1]),
        .Overrun(ov[1]), .Sync_Ack(ack[1]));

    data_sync_mc #(.NUM_STAGES(3), .BUS_WIDTH(8), .NUM_CH(3), .ENABLE_MODE(0), .OVERWRITE(1)) u_dut2 (
        .CLK(CLK), .RST(RST), .UNSYNC_BUS(ub[2]), .Bus_Enable(be[2]), .Data_Ready(rdy[2]),
        .Overrun_Clr(clr[2]), .SYNC_BUS(sb[2]), .Enable_Pulse(ep[2]), .Data_Valid(dv[2]),
        .Overrun(ov[2]), .Sync_Ack(ack[2]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int ns_of(input int i);
        return (i == 2) ? 3 : 2;
    endfunction

    function automatic bit toggle_of(input int i);
        return (i == 1);
    endfunction

    function automatic bit ow_of(input int i);
        return (i != 1);
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 3; c++) begin
                m_bus[i][c]   = 8'h00;
                m_valid[i][c] = 1'b0;
                m_pulse[i][c] = 1'b0;
                m_ovr[i][c]   = 1'b0;
                m_ack[i][c]   = 1'b0;
                m_hist[i][c]  = 8'h00;
            end
        end
    endtask

    task automatic model_update();
        bit nw, od, ev, r, ld, acc;
        int ns;
        if (!RST) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            ns = ns_of(i);
            for (int c = 0; c < 3; c++) begin
                nw  = m_hist[i][c][ns-1];
                od  = m_hist[i][c][ns];
                ev  = toggle_of(i) ? (nw != od) : (nw && !od);
                r   = rdy[i][c];
                ld  = ev && (!m_valid[i][c] || r || ow_of(i));
                acc = m_valid[i][c] && r;
                if (ev && m_valid[i][c] && !r) m_ovr[i][c] = 1'b1;
                else if (clr[i][c]) m_ovr[i][c] = 1'b0;
                if (acc) m_ack[i][c] = ~m_ack[i][c];
                m_pulse[i][c] = ld;
                if (ld) begin
                    m_bus[i][c]   = ub[i][c*8 +: 8];
                    m_valid[i][c] = 1'b1;
                end else if (acc) begin
                    m_valid[i][c] = 1'b0;
                end
                m_hist[i][c] = {m_hist[i][c][6:0], be[i][c]};
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("i%0d_sync_bus", i), sb[i], {m_bus[i][2], m_bus[i][1], m_bus[i][0]});
            chk($sformatf("i%0d_pulse", i), 24'(ep[i]), 24'({m_pulse[i][2], m_pulse[i][1], m_pulse[i][0]}));
            chk($sformatf("i%0d_valid", i), 24'(dv[i]), 24'({m_valid[i][2], m_valid[i][1], m_valid[i][0]}));
            chk($sformatf("i%0d_overrun", i), 24'(ov[i]), 24'({m_ovr[i][2], m_ovr[i][1], m_ovr[i][0]}));
            chk($sformatf("i%0d_ack", i), 24'(ack[i]), 24'({m_ack[i][2], m_ack[i][1], m_ack[i][0]}));
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        logic exp_ack;

        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ub[i] = '0; be[i] = '0; rdy[i] = '0; clr[i] = '0;
            for (int c = 0; c < 3; c++) hold[i][c] = 6;
        end
        model_reset();
        repeat (2) step();
        chk("rst_sync_bus", sb[0], 24'h0);
        chk("rst_valid", 24'(dv[2]), 24'h0);
        RST = 1'b1;
        repeat (2) step();

        // Latency: qualifier rises before edge 1, load lands at edge NS+1.
        for (int i = 0; i < 3; i++) begin
            ub[i][7:0] = 8'hA5;
            be[i][0]   = 1'b1;
        end
        step(); step();
        chk("lat_e2_pulse", 24'(ep[0][0]), 24'h0);
        step();
        chk("lat_e3_bus", 24'(sb[0][7:0]), 24'hA5);
        chk("lat_e3_pulse", 24'(ep[0][0]), 24'h1);
        chk("lat_e3_valid", 24'(dv[0][0]), 24'h1);
        chk("lat_e3_pulse_ns3", 24'(ep[2][0]), 24'h0);
        step();
        chk("lat_e4_pulse", 24'(ep[0][0]), 24'h0);
        chk("lat_e4_pulse_ns3", 24'(ep[2][0]), 24'h1);

        // Toggle mode on ch1: rise with 8'h11, fall with 8'h22, 8 cycles apart.
        for (int i = 0; i < 3; i++) begin
            rdy[i]      = 3'b111;
            ub[i][15:8] = 8'h11;
            be[i][1]    = 1'b1;
        end
        repeat (3) step();
        chk("tog_first_bus", 24'(sb[1][15:8]), 24'h11);
        chk("tog_first_pulse", 24'(ep[1][1]), 24'h1);
        repeat (5) step();
        for (int i = 0; i < 3; i++) begin
            ub[i][15:8] = 8'h22;
            be[i][1]    = 1'b0;
        end
        repeat (3) step();
        chk("tog_second_bus", 24'(sb[1][15:8]), 24'h22);
        chk("tog_second_pulse", 24'(ep[1][1]), 24'h1);
        chk("level_fall_no_load", 24'(sb[0][15:8]), 24'h11);
        repeat (2) step();

        // Overrun on ch2 with the consumer stalled.
        for (int i = 0; i < 3; i++) begin
            rdy[i]       = 3'b000;
            ub[i][23:16] = 8'h5A;
            be[i][2]     = 1'b1;
        end
        repeat (6) step();
        for (int i = 0; i < 3; i++) be[i][2] = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 3; i++) begin
            ub[i][23:16] = 8'h3C;
            be[i][2]     = 1'b1;
        end
        repeat (5) step();
        chk("ovr_set_ow1", 24'(ov[0][2]), 24'h1);
        chk("ovr_bus_ow1", 24'(sb[0][23:16]), 24'h3C);
        chk("ovr_set_ow0", 24'(ov[1][2]), 24'h1);
        chk("ovr_bus_ow0", 24'(sb[1][23:16]), 24'h5A);
        for (int i = 0; i < 3; i++) clr[i] = 3'b100;
        step();
        chk("ovr_clr_ow1", 24'(ov[0][2]), 24'h0);
        chk("ovr_clr_ow0", 24'(ov[1][2]), 24'h0);
        for (int i = 0; i < 3; i++) clr[i] = 3'b000;

        // Accept on the same edge as a new load (inst 0, ch0).
        for (int i = 0; i < 3; i++) be[i][0] = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 3; i++) begin
            ub[i][7:0] = 8'h77;
            be[i][0]   = 1'b1;
        end
        repeat (5) step();
        for (int i = 0; i < 3; i++) be[i][0] = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 3; i++) begin
            ub[i][7:0] = 8'h88;
            be[i][0]   = 1'b1;
        end
        step(); step();
        rdy[0]  = 3'b001;
        exp_ack = ~m_ack[0][0];
        step();
        chk("acc_load_valid", 24'(dv[0][0]), 24'h1);
        chk("acc_load_bus", 24'(sb[0][7:0]), 24'h88);
        chk("acc_load_ack", 24'(ack[0][0]), 24'(exp_ack));
        rdy[0] = 3'b000;
        step();

        // Simultaneous events on ch0 and ch2 of the NS=3 instance.
        for (int i = 0; i < 3; i++) begin
            be[i][0] = 1'b0;
            be[i][2] = 1'b0;
        end
        repeat (6) step();
        for (int i = 0; i < 3; i++) begin
            ub[i]    = 24'hE2_99_E0;
            be[i][0] = 1'b1;
            be[i][2] = 1'b1;
        end
        repeat (3) step();
        chk("multi_e3_pulse", 24'(ep[2]), 24'h0);
        step();
        chk("multi_e4_pulse", 24'(ep[2]), 24'h5);
        chk("multi_ch0_bus", 24'(sb[2][7:0]), 24'hE0);
        chk("multi_ch2_bus", 24'(sb[2][23:16]), 24'hE2);
        chk("multi_ch1_held", 24'(sb[2][15:8]), 24'h11);
        repeat (2) step();

        // Randomized traffic; each bus slice only changes together with its qualifier.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++) begin
                for (int c = 0; c < 3; c++) begin
                    if (hold[i][c] > 0) begin
                        hold[i][c]--;
                    end else if ($urandom_range(3) == 0) begin
                        be[i][c]          = ~be[i][c];
                        ub[i][c*8 +: 8]   = 8'($urandom);
                        hold[i][c]        = 6;
                    end
                end
                rdy[i] = 3'($urandom);
                clr[i] = ($urandom_range(7) == 0) ? 3'($urandom) : 3'b000;
            end
            step();
        end

        // Asynchronous reset mid-run with qualifiers held high through release.
        for (int i = 0; i < 3; i++) begin
            be[i]  = 3'b111;
            rdy[i] = 3'b000;
            clr[i] = 3'b000;
        end
        repeat (6) step();
        #3;
        RST = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("async_rst_bus_i%0d", i), sb[i], 24'h0);
            chk($sformatf("async_rst_pulse_i%0d", i), 24'(ep[i]), 24'h0);
            chk($sformatf("async_rst_valid_i%0d", i), 24'(dv[i]), 24'h0);
            chk($sformatf("async_rst_ovr_i%0d", i), 24'(ov[i]), 24'h0);
            chk($sformatf("async_rst_ack_i%0d", i), 24'(ack[i]), 24'h0);
        end
        repeat (2) step();
        RST = 1'b1;
        step(); step();
        chk("rel_e2_pulse", 24'(ep[0]), 24'h0);
        step();
        chk("rel_e3_pulse", 24'(ep[0]), 24'h7);
        chk("rel_e3_pulse_ns3", 24'(ep[2]), 24'h0);
        step();
        chk("rel_e4_pulse", 24'(ep[0]), 24'h0);
        chk("rel_e4_pulse_ns3", 24'(ep[2]), 24'h7);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
